alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, registered successor to the combinational 3-bit-opcode ALU, parametrised in operand width. Extends the ADD/AND/NOT set with SUB, OR, XOR and an iterative shift-add unsigned MUL. Adds carry and negative flags and a start/busy/done handshake so the control unit can issue operations and wait on a result. Sits between the register file and the writeback path of the CPU datapath.

## Interface

- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy = 0
- opcode  input  3  operation select, sampled with start
- a  input  WIDTH  first operand, sampled with start
- b  input  WIDTH  second operand, sampled with start
- busy  output  1  high while a MUL is iterating
- done  output  1  one-cycle pulse: res and flags updated this cycle
- res  output  WIDTH  registered result
- zero_flag  output  1  res == 0
- overflow_flag  output  1  signed overflow (ADD/SUB) or unsigned product overflow (MUL)
- carry_flag  output  1  ADD carry-out / SUB borrow
- negative_flag  output  1  res[WIDTH-1]

## Operation

- Opcodes: 000 ADD, 001 AND, 010 NOT (~a), 011 SUB (a-b), 100 OR, 101 XOR, 110 MUL, 111 undefined (res = 0).
- All arithmetic modulo 2^WIDTH; ADD/SUB computed in WIDTH+1 bits for carry/borrow.
- States: IDLE, MUL.
- IDLE, start = 1, opcode != 110: result and flags registered at that edge; done = 1 next cycle; stays IDLE.
- IDLE, start = 1, opcode = 110: latch a, b; clear 2*WIDTH-bit accumulator and counter (width $clog2(WIDTH+1)); busy = 1; go to MUL.
- MUL: each edge, if multiplier LSB = 1 add shifted multiplicand into accumulator; shift multiplicand left, multiplier right; counter++. On the WIDTH-th iteration edge: res = accumulator[WIDTH-1:0] (including that iteration), flags loaded, done = 1, busy = 0, go IDLE.
- start while busy = 1: ignored, operands not latched, no queued request.
- Flags on every completion: zero = (res == 0); negative = res[WIDTH-1].
- carry: ADD = carry-out; SUB = 1 iff a < b unsigned; else 0.
- overflow: ADD = a,b same sign and res sign differs; SUB = a,b signs differ and res sign differs from a; MUL = product[2*WIDTH-1:WIDTH] != 0; else 0.
- res and flags hold their values between completions; done is the only indication of new data.

## Timing

- Reset (rst high at an edge): state IDLE, busy = 0, done = 0, res = 0, all flags = 0, counter and accumulator cleared. Reset wins over start and over an in-flight MUL (aborted, no done).
- Single-cycle ops: latency 1 — start at edge k, done high in cycle after edge k, busy never asserted.
- MUL: start at edge k; busy high cycles after edges k..k+WIDTH-1; done high (busy low) in cycle after edge k+WIDTH. Latency WIDTH cycles.
- Back-to-back: start may be asserted in the same cycle done is high; new op accepted at that edge.
- done deasserts after one cycle unless a new single-cycle op is accepted at that edge (done stays high, new result).
- Operand inputs need not be held after the start edge.

## Test plan

- Reset: assert rst 2 cycles with start = 1 -> busy = 0, done = 0, res = 0x00, all flags 0.
- ADD, WIDTH = 8: a = 0x7F, b = 0x01 -> one cycle later done = 1, res = 0x80, overflow = 1, negative = 1, carry = 0, zero = 0; then a = 0xFF, b = 0x01 -> res = 0x00, zero = 1, carry = 1, overflow = 0.
- SUB: a = 0x00, b = 0x01 -> res = 0xFF, carry = 1, negative = 1, overflow = 0; a = 0x80, b = 0x01 -> res = 0x7F, overflow = 1.
- MUL: a = 0x0C, b = 0x0B -> busy high 8 cycles, then done = 1, res = 0x84, overflow = 0; a = 0x10, b = 0x10 -> res = 0x00, zero = 1, overflow = 1.
- Handshake: during MUL (a = 0x03, b = 0x05) pulse start with ADD 0x01 + 0x01 -> ignored, final res = 0x0F; same-cycle start on done with AND 0xF0 & 0x3C -> res = 0x30 next cycle, done stays high.
- Reset mid-MUL: rst at 4th busy cycle -> busy = 0, no done pulse, res = 0x00; opcode 111 afterwards -> res = 0x00, zero = 1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus an iterative shift-add MUL,
// with a registered result, flags and a start/busy/done handshake.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zero_flag,
    output logic             overflow_flag,
    output logic             carry_flag,
    output logic             negative_flag
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic carry;
        logic neg;
    } flags_t;

    state_t             state, state_n;
    logic [2*WIDTH-1:0] mcand, mcand_n, acc, acc_n, acc_add;
    logic [WIDTH-1:0]   mplier, mplier_n, res_q, res_n, r;
    logic [CW-1:0]      cnt, cnt_n;
    flags_t             flags_q, flags_n;
    logic               done_q, done_n, load, c, o;
    logic [WIDTH:0]     sum, diff;

    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        mplier_n = mplier;
        acc_n    = acc;
        cnt_n    = cnt;
        res_n    = res_q;
        flags_n  = flags_q;
        done_n   = 1'b0;
        load     = 1'b0;
        r        = '0;
        c        = 1'b0;
        o        = 1'b0;
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        acc_add  = acc + (mplier[0] ? mcand : '0);

        case (state)
            IDLE: begin
                if (start) begin
                    if (opcode == 3'b110) begin
                        mcand_n  = {{WIDTH{1'b0}}, a};
                        mplier_n = b;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = MUL;
                    end else begin
                        load = 1'b1;
                        case (opcode)
                            3'b000: begin
                                r = sum[WIDTH-1:0];
                                c = sum[WIDTH];
                                o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                            end
                            3'b001: r = a & b;
                            3'b010: r = ~a;
                            3'b011: begin
                                // borrow out of the extended subtraction means a < b unsigned
                                r = diff[WIDTH-1:0];
                                c = diff[WIDTH];
                                o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                            end
                            3'b100:  r = a | b;
                            3'b101:  r = a ^ b;
                            default: r = '0;
                        endcase
                    end
                end
            end
            MUL: begin
                acc_n    = acc_add;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + 1'b1;
                if (cnt == LAST) begin
                    load    = 1'b1;
                    r       = acc_add[WIDTH-1:0];
                    o       = |acc_add[2*WIDTH-1:WIDTH];
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            res_n   = r;
            flags_n = '{zero: (r == '0), ovf: o, carry: c, neg: r[WIDTH-1]};
            done_n  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            mcand   <= mcand_n;
            mplier  <= mplier_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            res_q   <= res_n;
            flags_q <= flags_n;
            done_q  <= done_n;
        end
    end

    assign busy          = (state == MUL);
    assign done          = done_q;
    assign res           = res_q;
    assign zero_flag     = flags_q.zero;
    assign overflow_flag = flags_q.ovf;
    assign carry_flag    = flags_q.carry;
    assign negative_flag = flags_q.neg;
endmodule

// File: tb/tb_alu_mc.sv
// Directed + random bench for alu_mc: expected results are queued at issue time
// and popped when done is observed.
module tb_alu_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   opcode;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] res;
    logic         zero_flag, overflow_flag, carry_flag, negative_flag;

    typedef struct {
        logic [W-1:0] res;
        logic z, o, c, n;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
        .busy(busy), .done(done), .res(res), .zero_flag(zero_flag),
        .overflow_flag(overflow_flag), .carry_flag(carry_flag),
        .negative_flag(negative_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [2:0] op, input int x, input int y);
        exp_t e;
        int sx = (x >= 128) ? x - 256 : x;
        int sy = (y >= 128) ? y - 256 : y;
        int r  = 0;
        e.c = 1'b0;
        e.o = 1'b0;
        case (op)
            3'd0: begin
                r   = x + y;
                e.c = (r > 255);
                e.o = (sx + sy > 127) || (sx + sy < -128);
            end
            3'd1: r = x & y;
            3'd2: r = ~x;
            3'd3: begin
                r   = x - y;
                e.c = (x < y);
                e.o = (sx - sy > 127) || (sx - sy < -128);
            end
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: begin
                r   = x * y;
                e.o = (r > 255);
            end
            default: r = 0;
        endcase
        e.res = r[7:0];
        e.z   = (r[7:0] == 8'h00);
        e.n   = r[7];
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push);
        opcode = op;
        a      = x;
        b      = y;
        start  = 1'b1;
        if (push) sb.push_back(model(op, int'(x), int'(y)));
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Wait (bounded) for done, counting busy cycles, then check against the scoreboard.
    task automatic finish(input string tag, input int exp_busy);
        exp_t e;
        int   n   = 0;
        int   cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) n++;
            cyc++;
            tick();
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({tag, ".busy_low"}, 32'(busy), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".res"}, 32'(res), 32'(e.res));
            chk({tag, ".zero"}, 32'(zero_flag), 32'(e.z));
            chk({tag, ".ovf"}, 32'(overflow_flag), 32'(e.o));
            chk({tag, ".carry"}, 32'(carry_flag), 32'(e.c));
            chk({tag, ".neg"}, 32'(negative_flag), 32'(e.n));
        end else begin
            tests++;
            fails++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end
    endtask

    initial begin
        int cnt;
        logic [2:0] rop;

        rst = 1'b1; start = 1'b1; opcode = 3'd0; a = 8'h01; b = 8'h01;
        tick();
        tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.res", 32'(res), 32'd0);
        chk("rst.flags", 32'({zero_flag, overflow_flag, carry_flag, negative_flag}), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        issue(3'd0, 8'h7F, 8'h01, 1'b1); finish("add_ovf", 0);
        issue(3'd0, 8'hFF, 8'h01, 1'b1); finish("add_carry", 0);
        tick();
        chk("add.done_pulse", 32'(done), 32'd0);
        chk("add.res_hold", 32'(res), 32'd0);
        issue(3'd3, 8'h00, 8'h01, 1'b1); finish("sub_borrow", 0);
        issue(3'd3, 8'h80, 8'h01, 1'b1); finish("sub_ovf", 0);
        issue(3'd2, 8'h5A, 8'h00, 1'b1); finish("not", 0);
        issue(3'd5, 8'hF0, 8'hFF, 1'b1); finish("xor", 0);

        issue(3'd6, 8'h0C, 8'h0B, 1'b1); finish("mul_0c0b", 8);
        issue(3'd6, 8'h10, 8'h10, 1'b1); finish("mul_ovf", 8);

        // start during MUL must be ignored; then a same-cycle start on done
        issue(3'd6, 8'h03, 8'h05, 1'b1);
        tick();
        tick();
        issue(3'd0, 8'h01, 8'h01, 1'b0);
        finish("mul_busy_ignore", 5);
        issue(3'd1, 8'hF0, 8'h3C, 1'b1);
        finish("and_on_done", 0);
        tick();
        chk("and.done_pulse", 32'(done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(6, 0));
            issue(rop, W'($urandom), W'($urandom), 1'b1);
            finish("rand", (rop == 3'd6) ? 8 : 0);
        end

        // reset on the 4th busy cycle aborts the MUL with no done
        issue(3'd6, 8'h03, 8'h05, 1'b0);
        tick();
        tick();
        tick();
        chk("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.res", 32'(res), 32'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) cnt++;
            tick();
        end
        chk("abort.no_done", 32'(cnt), 32'd0);
        issue(3'd7, 8'h05, 8'h03, 1'b1); finish("undef", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
